layer_1_maxpool2x2: RTL and testbench

Streaming 2x2 stride-2 max-pool stage placed directly downstream of a layer-0 feature-map block. It consumes one raster-ordered stream of IEEE-754 single-precision activations, IMG_SIZE x IMG_SIZE per frame, one pixel per valid_in cycle. It emits the (IMG_SIZE/2) x (IMG_SIZE/2) pooled map in raster order. One instance is used per feature map; there is no backpressure path.

---
 rtl/layer_1_maxpool2x2.sv | 138 +++++++++++++
 tb/tb_layer_1_maxpool2x2.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_1_maxpool2x2.sv
// layer_1_maxpool2x2
// Streaming 2x2 stride-2 max-pool over a raster-ordered IEEE-754 float32
// feature map. Pixel pairs are reduced horizontally as they arrive. Even rows
// park the horizontal maximum in a half-width row buffer. Odd rows combine it
// with the buffered value and emit one pooled pixel per 2x2 window.
// The float maximum is bitwise (sign/magnitude ordering) and uses no FP unit.
// Only DATA_WIDTH = 32 is supported.

module layer_1_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 416
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  // The output size is derived from the input size and cannot be overridden.
  localparam int OUT_SIZE = IMG_SIZE / 2;
  localparam int CNT_W    = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int ADDR_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);

  // Bitwise float maximum. When the signs differ, the non-negative operand
  // wins, so +0 beats -0. For two non-negatives the larger magnitude wins.
  // For two negatives the smaller magnitude wins. On a tie the result is a.
  function automatic logic [DATA_WIDTH-1:0] fmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    r = a;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      r = a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      if (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) r = b;
    end else begin
      if (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) r = b;
    end
    return r;
  endfunction

  // Position counters, pair latch and registered outputs.
  logic [CNT_W-1:0]      col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;

  // Row buffer: one horizontal maximum per output column. It is written on
  // even rows before any odd row reads it, so it needs no reset.
  logic [DATA_WIDTH-1:0] row_buf [OUT_SIZE];
  logic [ADDR_W-1:0]     buf_addr;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [DATA_WIDTH-1:0] horiz_max;
  logic                  col_last;
  logic                  row_last;

  assign buf_addr  = ADDR_W'(col_cnt_q >> 1);
  assign buf_rdata = row_buf[buf_addr];
  assign col_last  = (col_cnt_q == LAST_IDX);
  assign row_last  = (row_cnt_q == LAST_IDX);
  assign horiz_max = fmax(pair_q, data_in);

  // Next-state logic. Nothing advances on cycles where valid_in is low.
  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    pair_d       = pair_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;

    if (valid_in) begin
      // Raster position advance. The row wraps at the end of a frame so the
      // next frame may follow with no gap.
      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end

      if (!col_cnt_q[0]) begin
        // First pixel of a horizontal pair.
        pair_d = data_in;
      end else if (!row_cnt_q[0]) begin
        // Top half of a window: store the horizontal maximum.
        buf_we = 1'b1;
      end else begin
        // Bottom half: the buffered top maximum is the earlier operand.
        data_out_d   = fmax(buf_rdata, horiz_max);
        valid_out_d  = 1'b1;
        frame_done_d = col_last && row_last;
      end
    end
  end

  // State register with synchronous reset. A reset drops any pixel that
  // arrives in the same cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pair_q       <= pair_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffer write port. Reset gates the write so a dropped pixel leaves
  // no trace.
  always_ff @(posedge Clk) begin
    if (buf_we && !Rst) begin
      row_buf[buf_addr] <= horiz_max;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_layer_1_maxpool2x2.sv
// Bench for layer_1_maxpool2x2. The main instance uses a 4x4 frame and a
// second instance uses a 2x2 frame. The reference model keeps whole frames
// and pools each window with an ordered-key maximum.

module tb_layer_1_maxpool2x2;

  localparam int IMG = 4;
  localparam int NPIX = IMG * IMG;

  // ---------------- clock / reset / signals ----------------
  logic        clk;
  logic        rst_i;
  logic        valid_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  logic        rst2;
  logic        valid2;
  logic [31:0] data2;
  logic [31:0] data_out2;
  logic        valid_out2;
  logic        frame_done2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  layer_1_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(IMG)) dut (
    .Clk(clk), .Rst(rst_i), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done)
  );

  layer_1_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(2)) dut2 (
    .Clk(clk), .Rst(rst2), .data_in(data2), .valid_in(valid2),
    .data_out(data_out2), .valid_out(valid_out2), .frame_done(frame_done2)
  );

  // ---------------- scoreboard state ----------------
  int          total;
  int          bad;
  logic [32:0] exp_q[$];      // {frame_done, data}
  logic [31:0] cap_q[$];      // captured DUT outputs for golden checks
  logic [31:0] pix [NPIX];    // model copy of the current frame
  logic [31:0] frm [NPIX];    // frame to drive
  logic [31:0] ramp [NPIX];
  logic [31:0] pool [6];
  logic [31:0] last_out;
  int          idx;
  int          fd_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Total order on float bit patterns: negatives map below zero. -0 maps
  // just below +0. Equal keys imply identical bit patterns.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    return x[31] ? (-m - 1) : m;
  endfunction

  function automatic logic [31:0] ref_max4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    logic [31:0] m;
    m = a;
    if (fkey(b) > fkey(m)) m = b;
    if (fkey(c) > fkey(m)) m = c;
    if (fkey(d) > fkey(m)) m = d;
    return m;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle. The model is updated, the inputs are driven, and the
  // outputs are checked 1 time unit after the edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] d);
    logic        trig;
    logic [31:0] e;
    logic [32:0] ent;
    int          r;
    int          c;
    trig = 1'b0;
    rst_i = rst; valid_in = v; data_in = d;
    if (rst) begin
      idx = 0;
      exp_q.delete();
      last_out = '0;
    end else if (v) begin
      pix[idx] = d;
      r = idx / IMG;
      c = idx % IMG;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        trig = 1'b1;
        e = ref_max4(pix[(r-1)*IMG + c-1], pix[(r-1)*IMG + c], pix[r*IMG + c-1], pix[idx]);
        exp_q.push_back({(idx == NPIX-1), e});
      end
      idx = (idx + 1) % NPIX;
    end
    @(posedge clk); #1;
    rst_i = 1'b0; valid_in = 1'b0;
    chk("valid_out", {63'b0, valid_out}, {63'b0, trig});
    if (frame_done) fd_cnt++;
    if (valid_out && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      chk("data_out", {32'b0, data_out}, {32'b0, ent[31:0]});
      chk("frame_done", {63'b0, frame_done}, {63'b0, ent[32]});
      last_out = ent[31:0];
      cap_q.push_back(data_out);
    end else begin
      chk("frame_done_idle", {63'b0, frame_done}, 64'b0);
      chk("data_out_hold", {32'b0, data_out}, {32'b0, last_out});
    end
  endtask

  // Drive frm[] as one frame with a random bubble before each pixel with
  // probability pct percent.
  task automatic send_frame(input int pct);
    for (int i = 0; i < NPIX; i++) begin
      while ($urandom_range(0, 99) < pct) step(1'b0, 1'b0, $urandom);
      step(1'b0, 1'b1, frm[i]);
    end
  endtask

  task automatic check_cap(input string tag, input logic [31:0] g0, input logic [31:0] g1,
                           input logic [31:0] g2, input logic [31:0] g3);
    logic [31:0] g [4];
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    chk({tag, "_count"}, 64'(cap_q.size()), 64'd4);
    if (cap_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk({tag, "_val"}, {32'b0, cap_q[i]}, {32'b0, g[i]});
    end
  endtask

  task automatic step2(input logic r, input logic v, input logic [31:0] d);
    rst2 = r; valid2 = v; data2 = d;
    @(posedge clk); #1;
    rst2 = 1'b0; valid2 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0; bad = 0; idx = 0; fd_cnt = 0; last_out = '0;
    rst_i = 1'b1; valid_in = 1'b0; data_in = '0;
    rst2 = 1'b1; valid2 = 1'b0; data2 = '0;
    ramp[0]  = 32'h3F800000; ramp[1]  = 32'h40000000; ramp[2]  = 32'h40400000; ramp[3]  = 32'h40800000;
    ramp[4]  = 32'h40A00000; ramp[5]  = 32'h40C00000; ramp[6]  = 32'h40E00000; ramp[7]  = 32'h41000000;
    ramp[8]  = 32'h41100000; ramp[9]  = 32'h41200000; ramp[10] = 32'h41300000; ramp[11] = 32'h41400000;
    ramp[12] = 32'h41500000; ramp[13] = 32'h41600000; ramp[14] = 32'h41700000; ramp[15] = 32'h41800000;
    pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h3F800000;
    pool[3] = 32'hBF800000; pool[4] = 32'h40000000; pool[5] = 32'hC0000000;

    // Reset state.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h41800000);
    chk("reset_valid", {63'b0, valid_out}, 64'b0);
    chk("reset_data", {32'b0, data_out}, 64'b0);

    // Ramp 1..16, no bubbles.
    for (int i = 0; i < NPIX; i++) frm[i] = ramp[i];
    cap_q.delete(); fd_cnt = 0;
    send_frame(0);
    check_cap("ramp", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);
    chk("ramp_fd", 64'(fd_cnt), 64'd1);

    // All negative: -1.0 at (0,0), -5.0 elsewhere.
    for (int i = 0; i < NPIX; i++) frm[i] = 32'hC0A00000;
    frm[0] = 32'hBF800000;
    cap_q.delete();
    send_frame(0);
    check_cap("neg", 32'hBF800000, 32'hC0A00000, 32'hC0A00000, 32'hC0A00000);

    // Ramp with random bubbles.
    for (int i = 0; i < NPIX; i++) frm[i] = ramp[i];
    cap_q.delete();
    send_frame(40);
    check_cap("bubble", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

    // Back-to-back frames: ramp then reversed ramp.
    cap_q.delete(); fd_cnt = 0;
    send_frame(0);
    for (int i = 0; i < NPIX; i++) frm[i] = ramp[NPIX-1-i];
    cap_q.delete();
    send_frame(0);
    check_cap("reverse", 32'h41800000, 32'h41600000, 32'h41000000, 32'h40C00000);
    chk("b2b_fd", 64'(fd_cnt), 64'd2);

    // Abort after 9 pixels. The reset coincides with a pixel, which must be
    // dropped. A full ramp frame follows.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, ramp[i]);
    step(1'b1, 1'b1, 32'h41800000);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < NPIX; i++) frm[i] = ramp[i];
    cap_q.delete();
    send_frame(20);
    check_cap("after_rst", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

    // Random frames checked against the model.
    fd_cnt = 0;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++)
        frm[i] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      send_frame(30);
    end
    chk("rand_fd", 64'(fd_cnt), 64'd6);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    // 2x2 instance: signed zeros and negatives.
    step2(1'b1, 1'b0, '0);
    chk("d2_reset", {31'b0, valid_out2, data_out2}, 64'b0);
    step2(1'b0, 1'b1, 32'h80000000);
    step2(1'b0, 1'b1, 32'h00000000);
    step2(1'b0, 1'b1, 32'hC0000000);
    chk("d2_early", {63'b0, valid_out2}, 64'b0);
    step2(1'b0, 1'b1, 32'hC0400000);
    chk("d2_zero", {30'b0, frame_done2, valid_out2, data_out2}, {30'b0, 2'b11, 32'h00000000});
    step2(1'b0, 1'b0, '0);
    chk("d2_hold", {31'b0, valid_out2, data_out2}, {31'b0, 1'b0, 32'h00000000});
    step2(1'b0, 1'b1, 32'hBF800000);
    step2(1'b0, 1'b1, 32'h80000000);
    step2(1'b0, 1'b1, 32'hC0000000);
    step2(1'b0, 1'b1, 32'hBF000000);
    chk("d2_negzero", {30'b0, frame_done2, valid_out2, data_out2}, {30'b0, 2'b11, 32'h80000000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
